data_memory: RTL and testbench



---
 rtl/data_memory.sv | 73 +++++++
 tb/tb_data_memory.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// data_memory: fixed-latency word memory responder that stalls the MEM stage until each request completes.
// Optional misaligned-access checking is enabled by defining DATA_MEM_ALIGN_CHECK_EN.
module data_memory #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 2
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [15:0] MemAddr,
  input  logic [31:0] MemWriteData,
  output logic [31:0] MemData,
  output logic        MemValid,
  output logic        MemStall,
  output logic        AlignErr
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} stateT;
  logic [31:0] mem [DEPTH_WORDS];
  stateT state, nextState;
  logic [3:0] count;
  logic [AW-1:0] latIdx, selIdx;
  logic [31:0] latData, selData;
  logic latWrite, latMis, selWrite, selMis, reqMis;
  logic req, accept, enterDone, unusedAddr;
  assign unusedAddr = ^MemAddr;
  assign req = MemRead | MemWrite;
  assign accept = state == IDLE && req;
`ifdef DATA_MEM_ALIGN_CHECK_EN
  assign reqMis = MemAddr[1:0] != 2'b00;
  assign AlignErr = state == DONE && latMis;
`else
  assign reqMis = 1'b0;
  assign AlignErr = 1'b0;
`endif
  always_comb begin
    nextState = state == IDLE ? (req ? (LATENCY > 1 ? WAIT : DONE) : IDLE)
              : state == WAIT ? (count == 4'd1 ? DONE : WAIT) : IDLE;
  end
  // With LATENCY 1 the request commits on its acceptance edge, so take fields straight from the bus
  assign selIdx = state == IDLE ? MemAddr[AW+1:2] : latIdx;
  assign selData = state == IDLE ? MemWriteData : latData;
  assign selWrite = state == IDLE ? MemWrite : latWrite;
  assign selMis = state == IDLE ? reqMis : latMis;
  assign enterDone = nReset && nextState == DONE;
  assign MemStall = nReset && (accept || state == WAIT);
  assign MemValid = state == DONE;
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
      count <= 4'd0;
      latIdx <= '0;
      latData <= 32'h0;
      latWrite <= 1'b0;
      latMis <= 1'b0;
      MemData <= 32'h0;
    end else begin
      state <= nextState;
      if (accept) begin
        count <= 4'(LATENCY - 1);
        latIdx <= MemAddr[AW+1:2];
        latData <= MemWriteData;
        latWrite <= MemWrite;
        latMis <= reqMis;
      end else if (state == WAIT) count <= count - 4'd1;
      if (enterDone && !selWrite) MemData <= selMis ? 32'h0 : mem[selIdx];
    end
  end
  always_ff @(posedge Clock) begin
    if (enterDone && selWrite && !selMis) mem[selIdx] <= selData;
  end
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: table-driven and hand-sequenced checks of two data_memory configurations with a result scoreboard.
module tb_data_memory;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic aRstN, aRead, aWrite, aValid, aStall, aErr;
  logic [15:0] aAddr;
  logic [31:0] aWData, aData;
  logic bRstN, bRead, bWrite, bValid, bStall, bErr;
  logic [15:0] bAddr;
  logic [31:0] bWData, bData;
  data_memory #(.DEPTH_WORDS(1024), .LATENCY(2)) dutA (
    .Clock(clk), .nReset(aRstN), .MemRead(aRead), .MemWrite(aWrite), .MemAddr(aAddr),
    .MemWriteData(aWData), .MemData(aData), .MemValid(aValid), .MemStall(aStall), .AlignErr(aErr));
  data_memory #(.DEPTH_WORDS(16), .LATENCY(1)) dutB (
    .Clock(clk), .nReset(bRstN), .MemRead(bRead), .MemWrite(bWrite), .MemAddr(bAddr),
    .MemWriteData(bWData), .MemData(bData), .MemValid(bValid), .MemStall(bStall), .AlignErr(bErr));
`ifdef DATA_MEM_ALIGN_CHECK_EN
  localparam logic ALIGN = 1'b1;
`else
  localparam logic ALIGN = 1'b0;
`endif
  typedef struct {logic [31:0] data; logic err;} expT;
  typedef struct {logic rd; logic wr; logic [15:0] addr; logic [31:0] wd; logic [31:0] expD;} vecT;
  expT sb[$];
  vecT vecs[7];
  int checks = 0, errors = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask
  task automatic drive(input int inst, input logic rd, input logic wr, input logic [15:0] addr, input logic [31:0] wd);
    if (inst == 0) begin
      aRead = rd; aWrite = wr; aAddr = addr; aWData = wd;
    end else begin
      bRead = rd; bWrite = wr; bAddr = addr; bWData = wd;
    end
  endtask
  task automatic sample(input int inst, output logic stall, output logic valid, output logic err, output logic [31:0] data);
    stall = inst == 0 ? aStall : bStall;
    valid = inst == 0 ? aValid : bValid;
    err = inst == 0 ? aErr : bErr;
    data = inst == 0 ? aData : bData;
  endtask
  task automatic req(input int inst, input logic rd, input logic wr, input logic [15:0] addr,
                     input logic [31:0] wd, input logic [31:0] expD, input logic expErr, input string n);
    int lat;
    expT e, g;
    logic s, v, er;
    logic [31:0] d;
    lat = inst == 0 ? 2 : 1;
    drive(inst, rd, wr, addr, wd);
    e.data = expD; e.err = expErr;
    sb.push_back(e);
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      sample(inst, s, v, er, d);
      chk({n, " stall"}, 32'(s), 32'd1);
      chk({n, " early valid"}, 32'(v), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    sample(inst, s, v, er, d);
    chk({n, " valid"}, 32'(v), 32'd1);
    chk({n, " done stall"}, 32'(s), 32'd0);
    if (sb.size() == 0) chk({n, " scoreboard empty"}, 32'd1, 32'd0);
    else begin
      g = sb.pop_front();
      chk({n, " data"}, d, g.data);
      chk({n, " alignerr"}, 32'(er), 32'(g.err));
    end
    @(posedge clk); #1;
    drive(inst, 1'b0, 1'b0, 16'h0, 32'h0);
  endtask
  logic s, v, er;
  logic [31:0] d;
  initial begin
    vecs[0] = '{1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 16'h0100, 32'h01020304, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b1, 16'h07FC, 32'h55AA55AA, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 1'b0, 16'h0100, 32'h0, 32'h01020304};
    vecs[5] = '{1'b1, 1'b0, 16'h07FC, 32'h0, 32'h55AA55AA};
    vecs[6] = '{1'b1, 1'b0, 16'h1010, 32'h0, 32'hDEADBEEF};
    aRstN = 1'b0; bRstN = 1'b0;
    drive(0, 1'b1, 1'b0, 16'h0, 32'h0);
    drive(1, 1'b1, 1'b1, 16'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("reset stall", 32'(aStall), 32'd0);
    chk("reset valid", 32'(aValid), 32'd0);
    chk("reset data", aData, 32'h0);
    chk("reset alignerr", 32'(aErr), 32'd0);
    chk("reset b stall", 32'(bStall), 32'd0);
    chk("reset b data", bData, 32'h0);
    drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
    aRstN = 1'b1; bRstN = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++)
      req(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].expD, 1'b0, $sformatf("vec%0d", i));
    req(0, 1'b1, 1'b1, 16'h0020, 32'h12345678, 32'hDEADBEEF, 1'b0, "rdwr both");
    req(0, 1'b1, 1'b0, 16'h0020, 32'h0, 32'h12345678, 1'b0, "rd after both");
    req(0, 1'b0, 1'b1, 16'h0008, 32'h0, 32'h12345678, 1'b0, "w8 zero");
    drive(0, 1'b0, 1'b1, 16'h0008, 32'hFFFFFFFF);
    @(posedge clk); #1;
    chk("wait stall", 32'(aStall), 32'd1);
    aRstN = 1'b0;
    #1;
    chk("abort stall", 32'(aStall), 32'd0);
    chk("abort valid", 32'(aValid), 32'd0);
    chk("abort data", aData, 32'h0);
    drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    aRstN = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no completion after abort", 32'(aValid), 32'd0);
    end
    @(posedge clk); #1;
    req(0, 1'b1, 1'b0, 16'h0008, 32'h0, 32'h0, 1'b0, "rd8 after abort");
    req(0, 1'b0, 1'b1, 16'h0009, 32'hCAFEF00D, 32'h0, ALIGN, "misaligned wr");
    req(0, 1'b1, 1'b0, 16'h0008, 32'h0, ALIGN ? 32'h0 : 32'hCAFEF00D, 1'b0, "rd8 after misaligned");
    req(1, 1'b0, 1'b1, 16'h0004, 32'h11110004, 32'h0, 1'b0, "b w4");
    req(1, 1'b0, 1'b1, 16'h0040, 32'hA5A5A5A5, 32'h0, 1'b0, "b w40");
    req(1, 1'b1, 1'b0, 16'h0000, 32'h0, 32'hA5A5A5A5, 1'b0, "b alias rd0");
    drive(1, 1'b1, 1'b0, 16'h0000, 32'h0);
    @(negedge clk);
    sample(1, s, v, er, d);
    chk("b2b T stall", 32'(s), 32'd1);
    chk("b2b T valid", 32'(v), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    sample(1, s, v, er, d);
    chk("b2b T+1 valid", 32'(v), 32'd1);
    chk("b2b T+1 stall", 32'(s), 32'd0);
    chk("b2b T+1 data", d, 32'hA5A5A5A5);
    drive(1, 1'b1, 1'b0, 16'h0004, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    sample(1, s, v, er, d);
    chk("b2b T+2 stall", 32'(s), 32'd1);
    chk("b2b T+2 valid", 32'(v), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    sample(1, s, v, er, d);
    chk("b2b T+3 valid", 32'(v), 32'd1);
    chk("b2b T+3 data", d, 32'h11110004);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    chk("b idle valid", 32'(bValid), 32'd0);
    chk("b idle stall", 32'(bStall), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
